// File: rtl/operand_skid_buffer.sv
// Two-entry registered skid buffer on the ALU B-operand path, with synchronous flush.
// Define OPERAND_SKID_PARITY_EN to add a stored even-parity bit per entry (out_parity).
module operand_skid_buffer #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  input  logic             flush,
`ifdef OPERAND_SKID_PARITY_EN
  output logic             out_parity,
`endif
  output logic [1:0]       occupancy
);

  typedef enum logic [1:0] {
    StEmpty = 2'd0,
    StOne   = 2'd1,
    StFull  = 2'd2
  } state_e;

  // Parity rides in the top bit of each entry so it moves main<-skid with its data.
`ifdef OPERAND_SKID_PARITY_EN
  localparam int unsigned EW = WIDTH + 1;
`else
  localparam int unsigned EW = WIDTH;
`endif

  state_e        state_q, state_d;
  logic [EW-1:0] main_q, main_d;
  logic [EW-1:0] skid_q, skid_d;
  logic [EW-1:0] in_entry;
  logic          in_xfer, out_xfer;

`ifdef OPERAND_SKID_PARITY_EN
  assign in_entry = {^in_data, in_data};
`else
  assign in_entry = in_data;
`endif

  assign in_ready  = !rst && (state_q != StFull);
  assign out_valid = (state_q != StEmpty);
  assign out_data  = out_valid ? main_q[WIDTH-1:0] : '0;
  assign occupancy = state_q;
  assign in_xfer   = in_valid && in_ready;
  assign out_xfer  = out_valid && out_ready;

`ifdef OPERAND_SKID_PARITY_EN
  assign out_parity = out_valid && main_q[WIDTH];
`endif

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = StEmpty;
      main_d  = '0;
      skid_d  = '0;
    end else begin
      unique case (state_q)
        StEmpty: begin
          if (in_xfer) begin
            state_d = StOne;
            main_d  = in_entry;
          end
        end
        StOne: begin
          if (in_xfer && out_xfer) begin
            main_d = in_entry;
          end else if (in_xfer) begin
            state_d = StFull;
            skid_d  = in_entry;
          end else if (out_xfer) begin
            state_d = StEmpty;
            main_d  = '0;
          end
        end
        StFull: begin
          if (out_xfer) begin
            state_d = StOne;
            main_d  = skid_q;
            skid_d  = '0;
          end
        end
        default: begin
          state_d = StEmpty;
          main_d  = '0;
          skid_d  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StEmpty;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

endmodule

// File: tb/tb_operand_skid_buffer.sv
// Self-checking bench for operand_skid_buffer: directed scenarios then randomized traffic
// against a queue-based FIFO model.
module tb_operand_skid_buffer;

  localparam int unsigned WIDTH = 32;

  logic             clk;
  logic             rst;
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
  logic             flush;
  logic [1:0]       occupancy;
`ifdef OPERAND_SKID_PARITY_EN
  logic             out_parity;
`endif

  int n_checks = 0;
  int n_fails  = 0;

  logic [WIDTH-1:0] model_q[$];

  operand_skid_buffer #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .flush     (flush),
`ifdef OPERAND_SKID_PARITY_EN
    .out_parity(out_parity),
`endif
    .occupancy (occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic drive(input logic v, input logic [WIDTH-1:0] d, input logic r, input logic f);
    in_valid  = v;
    in_data   = d;
    out_ready = r;
    flush     = f;
  endtask

  // FIFO of at most two entries; flush or reset empties it.
  task automatic model_edge();
    bit in_x, out_x;
    if (rst) begin
      model_q.delete();
      return;
    end
    in_x  = in_valid && (model_q.size() < 2);
    out_x = out_ready && (model_q.size() > 0);
    if (flush) begin
      model_q.delete();
    end else begin
      if (out_x) void'(model_q.pop_front());
      if (in_x) model_q.push_back(in_data);
    end
  endtask

  task automatic compare_all(input string tag);
    logic [WIDTH-1:0] head;
    head = (model_q.size() > 0) ? model_q[0] : '0;
    check({tag, ".in_ready"}, 64'(in_ready), 64'(!rst && (model_q.size() < 2)));
    check({tag, ".out_valid"}, 64'(out_valid), 64'(model_q.size() != 0));
    check({tag, ".out_data"}, 64'(out_data), 64'(head));
    check({tag, ".occupancy"}, 64'(occupancy), 64'(model_q.size()));
`ifdef OPERAND_SKID_PARITY_EN
    check({tag, ".out_parity"}, 64'(out_parity), 64'(^head));
`endif
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    compare_all(tag);
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b1, 32'hDEADBEEF, 1'b0, 1'b0);

    // Reset hold with producer pushing
    for (int i = 0; i < 3; i++) begin
      step("reset");
      check("reset.in_ready0", 64'(in_ready), 64'd0);
      check("reset.data0", 64'(out_data), 64'd0);
    end
    rst = 1'b0;
    drive(1'b0, '0, 1'b1, 1'b0);
    #1;
    check("release.in_ready", 64'(in_ready), 64'd1);
    compare_all("release");

    // Streaming at full throughput
    for (int i = 1; i <= 3; i++) begin
      drive(1'b1, WIDTH'(i), 1'b1, 1'b0);
      step("stream");
      check("stream.data", 64'(out_data), 64'(i));
      check("stream.occ", 64'(occupancy), 64'd1);
      check("stream.in_ready", 64'(in_ready), 64'd1);
    end
    drive(1'b0, '0, 1'b1, 1'b0);
    step("stream_drain");

    // Backpressure
    drive(1'b1, 32'hA, 1'b0, 1'b0);
    step("bp_a");
    drive(1'b1, 32'hB, 1'b0, 1'b0);
    step("bp_b");
    check("bp.occ2", 64'(occupancy), 64'd2);
    check("bp.in_ready0", 64'(in_ready), 64'd0);
    drive(1'b1, 32'hE, 1'b0, 1'b0);
    step("bp_hold");
    check("bp.hold_a", 64'(out_data), 64'hA);
    drive(1'b0, '0, 1'b1, 1'b0);
    step("bp_pop1");
    check("bp.out_b", 64'(out_data), 64'hB);
    check("bp.occ1", 64'(occupancy), 64'd1);
    step("bp_pop2");
    check("bp.occ0", 64'(occupancy), 64'd0);

    // Flush while full, concurrent push of C is discarded
    drive(1'b1, 32'hA, 1'b0, 1'b0);
    step("fl_a");
    drive(1'b1, 32'hB, 1'b0, 1'b0);
    step("fl_b");
    drive(1'b1, 32'hC, 1'b1, 1'b1);
    step("flush");
    check("flush.occ", 64'(occupancy), 64'd0);
    check("flush.valid", 64'(out_valid), 64'd0);
    check("flush.data", 64'(out_data), 64'd0);
    drive(1'b0, '0, 1'b1, 1'b0);
    step("post_flush");

    // Asynchronous reset between edges while full
    drive(1'b1, 32'h11, 1'b0, 1'b0);
    step("ar_a");
    drive(1'b1, 32'h22, 1'b0, 1'b0);
    step("ar_b");
    drive(1'b0, '0, 1'b0, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    model_q.delete();
    check("async_rst.valid", 64'(out_valid), 64'd0);
    check("async_rst.data", 64'(out_data), 64'd0);
    compare_all("async_rst");
    step("async_rst_hold");
    rst = 1'b0;
    #1;
    compare_all("async_rst_release");

`ifdef OPERAND_SKID_PARITY_EN
    drive(1'b1, 32'h7, 1'b1, 1'b0);
    step("par7");
    check("par.seven", 64'(out_parity), 64'd1);
    drive(1'b1, 32'h3, 1'b1, 1'b0);
    step("par3");
    check("par.three", 64'(out_parity), 64'd0);
    drive(1'b0, '0, 1'b1, 1'b0);
    step("par_drain");
    check("par.drained", 64'(out_parity), 64'd0);
`endif

    // Randomized traffic with occasional flush and mid-cycle reset
    for (int i = 0; i < 3000; i++) begin
      drive(1'($urandom_range(0, 3) != 0), WIDTH'($urandom), 1'($urandom_range(0, 2) != 0),
            1'($urandom_range(0, 15) == 0));
      if ($urandom_range(0, 199) == 0) begin
        #2;
        rst = 1'b1;
        #1;
        model_q.delete();
        compare_all("rand_async_rst");
        step("rand_rst_edge");
        rst = 1'b0;
        #1;
        compare_all("rand_rst_release");
      end else begin
        step("rand");
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/operand_skid_buffer.md
Name: operand_skid_buffer

Overview:
- Two-entry registered skid buffer with valid/ready handshakes on both sides. Sits on the ALU B-operand path of the pipeline.
- Producer side: decode/register-read stage writes operands in. Consumer side: the execute stage drains them.
- Supports full throughput with registered backpressure. Provides a synchronous flush that zeroes the held operands on pipeline squash.
- Output data is forced to zero whenever nothing valid is held.

Parameters:
WIDTH, 32, operand width in bits

Ports:
clk  input  1  single clock, all state updates on rising edge
rst  input  1  asynchronous reset, active-high
in_data  input  WIDTH  operand from producer
in_valid  input  1  producer has an operand this cycle
in_ready  output  1  buffer can accept; in transfer = in_valid & in_ready
out_data  output  WIDTH  operand to consumer; all zeros when out_valid=0
out_valid  output  1  main register holds a valid operand
out_ready  input  1  consumer accepts; out transfer = out_valid & out_ready
flush  input  1  synchronous squash of all held operands
occupancy  output  2  number of held entries, 0..2

Behaviour:
- Interface: one clock (clk); reset rst is asynchronous and active-high.
- Storage: main register (drives out_data) and skid register, each WIDTH bits. State encodes occupancy: EMPTY=0, ONE=1, FULL=2.
- Reset (rst=1, asynchronous):
  - State goes to EMPTY; both data registers go to 0.
  - Outputs during and after reset: out_valid=0, out_data=0, occupancy=0.
  - in_ready=0 while rst=1. in_ready=1 from the first cycle rst=0.
- in_ready = !rst & (state != FULL). It depends only on state, never combinationally on out_ready.
- out_valid = (state != EMPTY). out_data = main register gated by out_valid.
- Latency: an operand accepted at edge N is visible on out_data after edge N. Throughput is 1 transfer per cycle.
- Transitions (flush=0):
  - EMPTY: in transfer -> ONE, main<=in_data. No in transfer -> stay.
  - ONE, in and out transfer -> ONE, main<=in_data.
  - ONE, in transfer only -> FULL, skid<=in_data, main unchanged.
  - ONE, out transfer only -> EMPTY, main<=0.
  - FULL: in_ready=0, so no in transfer is possible. Out transfer -> ONE, main<=skid, skid<=0. No out transfer -> stay.
- Order: FIFO. The skid entry is always younger than the main entry.
- Hold rule: while out_valid=1 and out_ready=0, out_data must not change.
- Flush (synchronous, highest priority over all transfers):
  - Next state is EMPTY; main and skid go to 0.
  - Any in transfer or out transfer in the same cycle is discarded; the consumer must ignore an out transfer in a flush cycle.
- in_data is ignored when in_valid=0. out_ready is ignored when out_valid=0.
- Reset mid-operation: held operands are discarded immediately. No partial transfer survives.
- occupancy equals the state encoding. It never reads 3.

Optional Feature:
- Macro: OPERAND_SKID_PARITY_EN.
- Defined:
  - Adds output out_parity (1 bit): the even parity (XOR reduction) of the main-register contents.
  - Parity is computed at capture time and stored alongside each entry. It moves main<-skid with its data.
  - out_parity is 0 when out_valid=0, on reset, and after flush.
- Undefined: the out_parity port and its storage do not exist. All other behaviour is identical.

Test Plan:
1. Reset release: hold rst=1 for 3 cycles with in_valid=1, in_data=32'hDEADBEEF -> in_ready=0, out_valid=0, out_data=0, occupancy=0. After release, in_ready=1 in the first cycle.
2. Streaming: out_ready=1, send 32'h1, 32'h2, 32'h3 on consecutive cycles -> out_data shows 1, 2, 3 one cycle later each. occupancy stays at 1; in_ready never drops.
3. Backpressure: out_ready=0, send 32'hA then 32'hB -> occupancy=2, in_ready=0, out_data holds 32'hA stable. Raise out_ready -> output sequence A then B; occupancy goes 2, 1, 0.
4. Flush when FULL with simultaneous in transfer: hold 32'hA and 32'hB, assert flush with in_valid=1 and in_data=32'hC -> next cycle occupancy=0, out_valid=0, out_data=0. 32'hC is never output.
5. Async reset mid-stream: assert rst between clock edges while FULL -> out_valid=0 and out_data=0 immediately, without waiting for a clock edge.
6. With OPERAND_SKID_PARITY_EN: send 32'h00000007, then 32'h00000003 -> out_parity=1, then out_parity=0. After drain, out_parity=0.
